// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the execution-stage hazard scheduler: operand
// select encodings, FSM state codes and the shadow-pipe entry layout.
// Forwarding is built in only when HAZARD_FORWARDING_EN is defined.
package hazard_control_unit_pkg;

    localparam int NUM_SHADOW = 4;   // DM1, DM2, DM3, WB
    localparam int REG_ADDR_W = 5;
    localparam int SEL_W      = 3;

    localparam logic [SEL_W-1:0] SEL_RS     = 3'd0;
    localparam logic [SEL_W-1:0] SEL_PC_IMM = 3'd1;
    localparam logic [SEL_W-1:0] SEL_DM1    = 3'd2;
    localparam logic [SEL_W-1:0] SEL_DM2    = 3'd3;
    localparam logic [SEL_W-1:0] SEL_DM3    = 3'd4;
    localparam logic [SEL_W-1:0] SEL_WB     = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_INTERLOCK = 2'd1,
        ST_FREEZE    = 2'd2
    } state_t;

    // is_load sits in bit 0 of the packed entry
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } shadow_t;

    localparam int SHADOW_W = $bits(shadow_t);

    // Writes to x0 or without write-enable never produce a forwardable value
    function automatic shadow_t make_entry(input logic [REG_ADDR_W-1:0] rd,
                                           input logic                  we,
                                           input logic [2:0]            load);
        shadow_t e;
        e.valid   = we && (rd != '0);
        e.rd      = rd;
        e.is_load = |load;
        return e;
    endfunction

    // Forwarding select for shadow slot 0..3
    function automatic logic [SEL_W-1:0] stage_sel(input int idx);
        case (idx)
            0:       return SEL_DM1;
            1:       return SEL_DM2;
            2:       return SEL_DM3;
            default: return SEL_WB;
        endcase
    endfunction

endpackage

// File: rtl/hazard_control_unit_match.sv
// One operand's view of the shadow pipe: finds the youngest in-flight
// producer of rs and reports either a forwarding select or a hazard.
// With HAZARD_FORWARDING_EN only a load still short of WB is a hazard;
// without it any producer still in DM1..WB is a hazard.
module hazard_match
    import hazard_control_unit_pkg::*;
(
    input  logic [REG_ADDR_W-1:0]              i_rs,
    input  logic                               i_used,
    input  logic [NUM_SHADOW-1:0][SHADOW_W-1:0] i_entries,
    output logic [SEL_W-1:0]                   o_select,
    output logic                               o_load_hit
);

    logic    w_found;
    shadow_t w_e;

    // Scan DM1 first so the youngest producer wins
    always_comb begin
        o_select   = SEL_RS;
        o_load_hit = 1'b0;
        w_found    = 1'b0;
        w_e        = '0;
        for (int i = 0; i < NUM_SHADOW; i++) begin
            w_e = shadow_t'(i_entries[i]);
            if (!w_found && i_used && (i_rs != '0) && w_e.valid && (w_e.rd == i_rs)) begin
                w_found = 1'b1;
`ifdef HAZARD_FORWARDING_EN
                // load data only exists once the producer reaches WB
                if (w_e.is_load && (i < NUM_SHADOW - 1))
                    o_load_hit = 1'b1;
                else
                    o_select = stage_sel(i);
`else
                o_load_hit = 1'b1;
`endif
            end
        end
    end

`ifndef HAZARD_FORWARDING_EN
    // Load flags only matter when forwarding is built in
    logic w_unused_load;
    always_comb begin
        w_unused_load = 1'b0;
        for (int i = 0; i < NUM_SHADOW; i++)
            w_unused_load = w_unused_load ^ i_entries[i][0];
    end
`endif

endmodule

// File: rtl/hazard_control_unit.sv
// Execution-stage hazard scheduler: shadow pipe of in-flight writers
// (DM1..WB), ALU operand forwarding selects, load-use interlock, data
// cache freeze, branch flush and a saturating stall-cycle counter.
// Build option: HAZARD_FORWARDING_EN enables DM1..WB forwarding; without
// it every RAW dependence interlocks until the producer retires.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter logic HIGH          = 1'b1,
    parameter logic LOW           = 1'b0,
    parameter int   COUNTER_WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [REG_ADDR_W-1:0]    i_rs1_address,
    input  logic [REG_ADDR_W-1:0]    i_rs2_address,
    input  logic                     i_rs1_used,
    input  logic                     i_rs2_used,
    input  logic                     i_alu_in1_pc_select,
    input  logic                     i_alu_in2_imm_select,
    input  logic [REG_ADDR_W-1:0]    i_rd_address_ex,
    input  logic                     i_rd_write_enable_ex,
    input  logic [2:0]               i_data_cache_load_ex,
    input  logic                     i_branch_taken,
    input  logic                     i_data_cache_ready,
    output logic [SEL_W-1:0]         o_alu_in1_mux_select,
    output logic [SEL_W-1:0]         o_alu_in2_mux_select,
    output logic                     o_stall_fetch_stage,
    output logic                     o_stall_decode_stage,
    output logic                     o_stall_execution_stage,
    output logic                     o_bubble_execution_stage,
    output logic                     o_stall_data_memory,
    output logic                     o_flush_fetch_stage,
    output logic                     o_flush_decode_stage,
    output logic [COUNTER_WIDTH-1:0] o_stall_cycle_count
);

    logic [NUM_SHADOW-1:0][SHADOW_W-1:0] r_shadow;   // [0]=DM1 .. [3]=WB
    state_t                              r_state;
    logic [COUNTER_WIDTH-1:0]            r_count;

    shadow_t          w_ex_entry;
    shadow_t          w_dm1_in;
    logic             w_used1, w_used2;
    logic [SEL_W-1:0] w_fwd_sel1, w_fwd_sel2;
    logic             w_hit1, w_hit2, w_hazard;
    state_t           w_mode;

    // Operands taken from PC/IMM never need a register value
    assign w_used1    = i_rs1_used && !i_alu_in1_pc_select;
    assign w_used2    = i_rs2_used && !i_alu_in2_imm_select;
    assign w_ex_entry = make_entry(i_rd_address_ex, i_rd_write_enable_ex, i_data_cache_load_ex);

    hazard_match u_match_in1 (
        .i_rs       (i_rs1_address),
        .i_used     (w_used1),
        .i_entries  (r_shadow),
        .o_select   (w_fwd_sel1),
        .o_load_hit (w_hit1)
    );

    hazard_match u_match_in2 (
        .i_rs       (i_rs2_address),
        .i_used     (w_used2),
        .i_entries  (r_shadow),
        .o_select   (w_fwd_sel2),
        .o_load_hit (w_hit2)
    );

    assign w_hazard = w_hit1 || w_hit2;

    // FSM transition; outputs decode the state entered this cycle so the
    // interlock and freeze take effect with no added latency
    always_comb begin
        w_mode = ST_RUN;
        case (r_state)
            ST_RUN:       w_mode = !i_data_cache_ready ? ST_FREEZE :
                                   w_hazard ? ST_INTERLOCK : ST_RUN;
            ST_INTERLOCK: w_mode = !i_data_cache_ready ? ST_FREEZE :
                                   !w_hazard ? ST_RUN : ST_INTERLOCK;
            // leaving FREEZE re-checks the hazard in the same cycle
            ST_FREEZE:    w_mode = !i_data_cache_ready ? ST_FREEZE :
                                   w_hazard ? ST_INTERLOCK : ST_RUN;
            default:      w_mode = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= ST_RUN;
        else
            r_state <= w_mode;
    end

    // A bubble enters DM1 while EX is held by the interlock
    assign w_dm1_in = (w_mode == ST_INTERLOCK) ? shadow_t'('0) : w_ex_entry;

    // Shadow pipe advances every cycle except during a cache freeze
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_shadow <= '0;
        else if (w_mode != ST_FREEZE)
            r_shadow <= {r_shadow[NUM_SHADOW-2:0], w_dm1_in};
    end

    // Saturating count of interlock and freeze cycles
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_count <= '0;
        else if ((w_mode != ST_RUN) && (r_count != '1))
            r_count <= r_count + 1'b1;
    end

    assign o_stall_cycle_count = r_count;

    // Stage controls and operand selects
    always_comb begin
        o_alu_in1_mux_select     = i_alu_in1_pc_select  ? SEL_PC_IMM : w_fwd_sel1;
        o_alu_in2_mux_select     = i_alu_in2_imm_select ? SEL_PC_IMM : w_fwd_sel2;
        o_stall_fetch_stage      = LOW;
        o_stall_decode_stage     = LOW;
        o_stall_execution_stage  = LOW;
        o_bubble_execution_stage = LOW;
        o_stall_data_memory      = LOW;
        o_flush_fetch_stage      = LOW;
        o_flush_decode_stage     = LOW;
        case (w_mode)
            ST_INTERLOCK: begin
                o_alu_in1_mux_select     = SEL_RS;
                o_alu_in2_mux_select     = SEL_RS;
                o_stall_fetch_stage      = HIGH;
                o_stall_decode_stage     = HIGH;
                o_bubble_execution_stage = HIGH;
            end
            ST_FREEZE: begin
                o_stall_fetch_stage      = HIGH;
                o_stall_decode_stage     = HIGH;
                o_stall_execution_stage  = HIGH;
                o_stall_data_memory      = HIGH;
            end
            default: begin
                // RUN implies no hazard and cache ready
                o_flush_fetch_stage  = i_branch_taken;
                o_flush_decode_stage = i_branch_taken;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit. Expectations follow the build:
// HAZARD_FORWARDING_EN selects the forwarding variant.
module tb_hazard_control_unit;

    logic       clk;
    logic       rst;
    logic [4:0] rs1, rs2, rd_ex;
    logic       u1, u2, pc_sel, imm_sel, we_ex, br, rdy;
    logic [2:0] ld_ex;
    logic [2:0] sel1, sel2;
    logic       sf, sd, se, bub, sdm, ff, fd;
    logic [31:0] cnt;
    logic [6:0] ctl_obs;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt;

    // {stall_fetch, stall_decode, stall_ex, bubble, stall_dm, flush_f, flush_d}
    localparam logic [6:0] C_RUN = 7'b0000000;
    localparam logic [6:0] C_IL  = 7'b1101000;
    localparam logic [6:0] C_FRZ = 7'b1110100;
    localparam logic [6:0] C_FL  = 7'b0000011;

    typedef struct {
        string       tag;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [6:0]  ctl;
        logic        csel;
        logic [31:0] cnt;
    } exp_t;

    exp_t sbq[$];

    hazard_control_unit dut (
        .i_clk                    (clk),
        .i_rst                    (rst),
        .i_rs1_address            (rs1),
        .i_rs2_address            (rs2),
        .i_rs1_used               (u1),
        .i_rs2_used               (u2),
        .i_alu_in1_pc_select      (pc_sel),
        .i_alu_in2_imm_select     (imm_sel),
        .i_rd_address_ex          (rd_ex),
        .i_rd_write_enable_ex     (we_ex),
        .i_data_cache_load_ex     (ld_ex),
        .i_branch_taken           (br),
        .i_data_cache_ready       (rdy),
        .o_alu_in1_mux_select     (sel1),
        .o_alu_in2_mux_select     (sel2),
        .o_stall_fetch_stage      (sf),
        .o_stall_decode_stage     (sd),
        .o_stall_execution_stage  (se),
        .o_bubble_execution_stage (bub),
        .o_stall_data_memory      (sdm),
        .o_flush_fetch_stage      (ff),
        .o_flush_decode_stage     (fd),
        .o_stall_cycle_count      (cnt)
    );

    assign ctl_obs = {sf, sd, se, bub, sdm, ff, fd};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drv(input int rd, input int we, input int ld, input int a1, input int a2,
                       input int eu1, input int eu2, input int pc, input int imm,
                       input int b, input int ready);
        rd_ex   = 5'(rd);
        we_ex   = (we != 0);
        ld_ex   = 3'(ld);
        rs1     = 5'(a1);
        rs2     = 5'(a2);
        u1      = (eu1 != 0);
        u2      = (eu2 != 0);
        pc_sel  = (pc != 0);
        imm_sel = (imm != 0);
        br      = (b != 0);
        rdy     = (ready != 0);
    endtask

    // Push the expectation, compare mid low-phase, then advance one cycle
    task automatic chk(input string tag, input int e1, input int e2,
                       input logic [6:0] ec, input int csel);
        exp_t e;
        sbq.push_back('{tag, 3'(e1), 3'(e2), ec, (csel != 0), exp_cnt});
        #2;
        e = sbq.pop_front();
        if (e.csel) begin
            checks++;
            assert (sel1 === e.s1) else begin
                errors++;
                $error("FAIL %s sel1: observed %0d expected %0d", e.tag, sel1, e.s1);
            end
            checks++;
            assert (sel2 === e.s2) else begin
                errors++;
                $error("FAIL %s sel2: observed %0d expected %0d", e.tag, sel2, e.s2);
            end
        end
        checks++;
        assert (ctl_obs === e.ctl) else begin
            errors++;
            $error("FAIL %s ctl: observed %b expected %b", e.tag, ctl_obs, e.ctl);
        end
        checks++;
        assert (cnt === e.cnt) else begin
            errors++;
            $error("FAIL %s count: observed %0d expected %0d", e.tag, cnt, e.cnt);
        end
        if (e.ctl[6]) exp_cnt++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            chk("idle", 0, 0, C_RUN, 1);
        end
    endtask

    initial begin
        exp_cnt = '0;
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset", 0, 0, C_RUN, 1);

        // 1: add x5 ; add x6,x5,x1
        drv(5, 1, 0, 1, 2, 1, 1, 0, 0, 0, 1);
        chk("t1_add_x5", 0, 0, C_RUN, 1);
        drv(6, 1, 0, 5, 1, 1, 1, 0, 0, 0, 1);
`ifdef HAZARD_FORWARDING_EN
        chk("t1_fwd_dm1", 2, 0, C_RUN, 1);
`else
        repeat (4) chk("t1_raw_stall", 0, 0, C_IL, 1);
        chk("t1_release", 0, 0, C_RUN, 1);
`endif
        idle(4);

        // 2: lw x5 ; add x6,x5,x5
        drv(5, 1, 2, 1, 0, 1, 0, 0, 1, 0, 1);
        chk("t2_lw", 0, 1, C_RUN, 1);
        drv(6, 1, 0, 5, 5, 1, 1, 0, 0, 0, 1);
`ifdef HAZARD_FORWARDING_EN
        repeat (3) chk("t2_load_use", 0, 0, C_IL, 1);
        chk("t2_wb_fwd", 5, 5, C_RUN, 1);
`else
        repeat (4) chk("t2_raw_stall", 0, 0, C_IL, 1);
        chk("t2_release", 0, 0, C_RUN, 1);
`endif
        idle(4);

        // 3: addi x0 ; add x6,x0,x0 ; lui x7 in DM1 and DM3
        drv(0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1);
        chk("t3_addi_x0", 0, 1, C_RUN, 1);
        drv(6, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        chk("t3_x0_src", 0, 0, C_RUN, 1);
        drv(7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("t3_lui_a", 0, 1, C_RUN, 1);
        idle(1);
        drv(7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("t3_lui_b", 0, 1, C_RUN, 1);
        drv(8, 1, 0, 7, 7, 1, 1, 0, 0, 0, 1);
`ifdef HAZARD_FORWARDING_EN
        chk("t3_dm1_wins", 2, 2, C_RUN, 1);
`else
        repeat (4) chk("t3_raw_stall", 0, 0, C_IL, 1);
        chk("t3_release", 0, 0, C_RUN, 1);
`endif
        idle(4);

        // 4: cache miss for 4 cycles during a load-use interlock
        drv(5, 1, 2, 1, 0, 1, 0, 0, 1, 0, 1);
        chk("t4_lw", 0, 1, C_RUN, 1);
        drv(6, 1, 0, 5, 1, 1, 1, 0, 0, 0, 1);
        chk("t4_interlock", 0, 0, C_IL, 1);
        drv(6, 1, 0, 5, 1, 1, 1, 0, 0, 0, 0);
        chk("t4_freeze", 0, 0, C_FRZ, 0);
        drv(6, 1, 0, 5, 1, 1, 1, 0, 0, 1, 0);
        chk("t4_freeze_br", 0, 0, C_FRZ, 0);
        drv(6, 1, 0, 5, 1, 1, 1, 0, 0, 0, 0);
        repeat (2) chk("t4_freeze", 0, 0, C_FRZ, 0);
        drv(6, 1, 0, 5, 1, 1, 1, 0, 0, 0, 1);
`ifdef HAZARD_FORWARDING_EN
        repeat (2) chk("t4_resume", 0, 0, C_IL, 1);
        chk("t4_wb_fwd", 5, 0, C_RUN, 1);
`else
        repeat (3) chk("t4_resume", 0, 0, C_IL, 1);
        chk("t4_release", 0, 0, C_RUN, 1);
`endif
        idle(4);

        // 5: branch in RUN flushes once; branch during interlock ignored
        drv(0, 0, 0, 1, 2, 1, 1, 0, 0, 1, 1);
        chk("t5_flush", 0, 0, C_FL, 1);
        idle(1);
        drv(5, 1, 2, 1, 0, 1, 0, 0, 1, 0, 1);
        chk("t5_lw", 0, 1, C_RUN, 1);
        drv(6, 1, 0, 5, 1, 1, 1, 0, 0, 1, 1);
        chk("t5_br_in_il", 0, 0, C_IL, 1);

        // 6: reset in the middle of an interlock
        rst = 1'b1;
        drv(6, 1, 0, 5, 1, 1, 1, 0, 0, 0, 1);
        chk("t6_rst_cycle", 0, 0, C_IL, 1);
        exp_cnt = '0;
        rst = 1'b0;
        chk("t6_after_rst", 0, 0, C_RUN, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
